bch_dec_seq: RTL
================

Name: bch_dec_seq

Overview:
Frame sequencer for the BCH(63,56) receive path. Accepts codeword bits serially, drives the syndrome accumulator's clear/shift enables, and issues the one-cycle isEn2 strobe that launches the syndrome-to-locator decoder stage. After a fixed decoder latency it steps the correction stage through all bit positions under output backpressure. It is the only block that sequences syndrome, decoder and correction stages; those stages hold no frame state of their own.

Parameters:
N, 63, codeword length in bits; legal range 8..64.
DEC_LAT, 1, cycles from the isEn2 cycle until decoder outputs s1/s2 are valid; legal range 1..15.
FCW, 16, width of frame_cnt.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  serial codeword bit valid.
in_sof  in  1  qualifies in_bit as bit 0 of a frame.
in_bit  in  1  codeword bit; passed through to the syndrome stage, not stored here.
in_ready  out  1  bit accepted when in_valid & in_ready.
syn_clr  out  1  combinational; clear syndrome register and load current bit.
syn_en  out  1  combinational; shift syndrome register with in_bit.
isEn2  out  1  registered one-cycle strobe to the decoder stage.
corr_en  out  1  correction stage active; equals out_valid.
corr_idx  out  6  bit position under correction, 0..N-1.
corr_last  out  1  corr_idx == N-1 while corr_en.
out_valid  in/out  1  output direction; corrected bit at corr_idx is valid.
out_ready  in  1  downstream accepts a corrected bit.
proto_err  out  1  registered one-cycle pulse; in_sof seen mid-frame.
frame_cnt  out  FCW  count of completed frames; wraps modulo 2^FCW.

Behaviour:
- States: IDLE, RECV, DECODE, CORRECT. All state and registered outputs go to IDLE/0 asynchronously on rst_n low, including mid-frame. Reset values: isEn2=0, corr_idx=0, proto_err=0, frame_cnt=0. Combinational outputs follow from IDLE: in_ready=1, out_valid=0.
- Bit counter bcnt is a 6-bit register. acc = in_valid & in_ready.
- IDLE: in_ready=1.
  - acc & in_sof: syn_clr=1, syn_en=1, bcnt<=1, go to RECV.
  - acc & !in_sof: bit dropped silently. syn_en=0, no error.
- RECV: in_ready=1.
  - acc & !in_sof: syn_en=1, bcnt<=bcnt+1.
  - in_valid low: hold all state.
  - acc with bcnt==N-1: last bit. Go to DECODE; isEn2=1 in the first DECODE cycle only.
  - acc & in_sof: frame restart. syn_clr=1, syn_en=1, bcnt<=1, proto_err=1 next cycle, stay in RECV. Restart takes priority over the last-bit check.
- DECODE: in_ready=0. The wait counter loads DEC_LAT on entry and decrements each cycle. Go to CORRECT when it reaches 0, so CORRECT starts DEC_LAT+1 cycles after the last-bit edge. in_sof/in_valid are ignored; no proto_err.
- CORRECT: in_ready=0, out_valid=corr_en=1, corr_idx starts at 0.
  - out_ready: corr_idx<=corr_idx+1.
  - out_ready low: hold corr_idx.
  - Handshake with corr_last: corr_idx<=0, frame_cnt<=frame_cnt+1 (wraps), go to IDLE. in_ready=1 on the next cycle.
- Decoder enable is the isEn2 pulse only. The decoder's own sticky enable output is not used for sequencing.
- No frame overlap: a new frame can start no earlier than the cycle after corr_last handshakes.

Decomposition:
- Package bch_pkg: state enum (IDLE, RECV, DECODE, CORRECT), BCH_N=63, BCH_K=56, BCH_M=6, and the shared index width.
- One natural sub-module: bch_seq_cnt, a loadable up/down counter reused for bcnt, the DECODE wait counter and corr_idx.
- FSM and handshake logic stay in bch_dec_seq.

Test Plan:
- Single frame, in_valid held 1, out_ready held 1.
  - syn_clr exactly once, syn_en 63 cycles, isEn2 one pulse 1 cycle after bit 62.
  - corr_en rises 2 cycles after bit 62 (DEC_LAT=1) and stays high 63 cycles, corr_last on idx 62.
  - frame_cnt=1; in_ready=0 from DECODE entry until the cycle after corr_last.
- Gapped input (in_valid toggles 1010…) plus random out_ready.
  - Exactly 63 syn_en pulses.
  - corr_idx never skips or repeats under stalls.
  - isEn2 still a single pulse.
- in_sof at bit 20 mid-frame.
  - proto_err pulses once, syn_clr reasserted.
  - isEn2 fires only after 63 further bits from the restart.
- Non-sof bits in IDLE (10 bits), then a valid frame.
  - No syn_en during the 10 bits, no error.
  - Frame processed normally.
- rst_n low for 1 cycle mid-CORRECT at corr_idx=30.
  - All outputs return to reset values, frame_cnt=0.
  - The next frame sequences from corr_idx=0.
- DEC_LAT=4 build, 2^16+1 frames (or FCW=4 with 17 frames).
  - CORRECT starts 5 cycles after last bit.
  - frame_cnt wraps to 1.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared types and constants for the BCH(63,56) receive-path sequencer.
package bch_pkg;

    localparam int unsigned BCH_N  = 63;
    localparam int unsigned BCH_K  = 56;
    localparam int unsigned BCH_M  = 6;
    // Bit positions 0..63 fit in BCH_M bits, so the index width tracks the field size.
    localparam int unsigned IDX_W  = BCH_M;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDecode,
        StCorrect
    } seq_state_e;

endpackage

// File: rtl/bch_seq_cnt.sv
// Loadable up/down counter; load wins over up, up wins over down.
module bch_seq_cnt
    import bch_pkg::*;
#(
    parameter int unsigned W = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         up_i,
    input  logic         down_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (up_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (down_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bch_dec_seq.sv
// Frame sequencer for the BCH(63,56) receive path: serial intake, decoder launch strobe,
// fixed decoder wait and backpressured per-bit correction stepping.
module bch_dec_seq
    import bch_pkg::*;
#(
    parameter int unsigned N       = BCH_N,
    parameter int unsigned DEC_LAT = 1,
    parameter int unsigned FCW     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             syn_clr,
    output logic             syn_en,
    output logic             isEn2,
    output logic             corr_en,
    output logic [IDX_W-1:0] corr_idx,
    output logic             corr_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             proto_err,
    output logic [FCW-1:0]   frame_cnt
);

    localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(N - 1);
    localparam logic [WAIT_W-1:0] LatVal  = WAIT_W'(DEC_LAT);

    seq_state_e state_d, state_q;
    logic       is_en2_d, is_en2_q;
    logic       proto_err_d, proto_err_q;
    logic [FCW-1:0] frame_cnt_d, frame_cnt_q;

    logic [IDX_W-1:0]  bcnt;
    logic              bcnt_load, bcnt_up;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_load, wait_down;
    logic              idx_clr, idx_up;

    // The bit itself goes straight to the syndrome stage; nothing here depends on it.
    logic unused_in_bit;
    assign unused_in_bit = in_bit;

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        syn_clr     = 1'b0;
        syn_en      = 1'b0;
        corr_en     = 1'b0;
        bcnt_load   = 1'b0;
        bcnt_up     = 1'b0;
        wait_load   = 1'b0;
        wait_down   = 1'b0;
        idx_clr     = 1'b0;
        idx_up      = 1'b0;
        is_en2_d    = 1'b0;
        proto_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                // Bits without sof are dropped silently while idle.
                if (in_valid && in_sof) begin
                    syn_clr   = 1'b1;
                    syn_en    = 1'b1;
                    bcnt_load = 1'b1;
                    state_d   = StRecv;
                end
            end
            StRecv: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    syn_en = 1'b1;
                    // A restart outranks the last-bit check.
                    if (in_sof) begin
                        syn_clr     = 1'b1;
                        bcnt_load   = 1'b1;
                        proto_err_d = 1'b1;
                    end else if (bcnt == LastIdx) begin
                        is_en2_d  = 1'b1;
                        wait_load = 1'b1;
                        state_d   = StDecode;
                    end else begin
                        bcnt_up = 1'b1;
                    end
                end
            end
            StDecode: begin
                wait_down = 1'b1;
                if (wait_cnt == WAIT_W'(1)) begin
                    state_d = StCorrect;
                end
            end
            StCorrect: begin
                corr_en = 1'b1;
                if (out_ready) begin
                    if (corr_idx == LastIdx) begin
                        idx_clr     = 1'b1;
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                        state_d     = StIdle;
                    end else begin
                        idx_up = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            is_en2_q    <= 1'b0;
            proto_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            is_en2_q    <= is_en2_d;
            proto_err_q <= proto_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    bch_seq_cnt #(
        .W (IDX_W)
    ) u_bcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (bcnt_load),
        .load_val_i (IDX_W'(1)),
        .up_i       (bcnt_up),
        .down_i     (1'b0),
        .cnt_o      (bcnt)
    );

    bch_seq_cnt #(
        .W (WAIT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (wait_load),
        .load_val_i (LatVal),
        .up_i       (1'b0),
        .down_i     (wait_down),
        .cnt_o      (wait_cnt)
    );

    bch_seq_cnt #(
        .W (IDX_W)
    ) u_corr_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (idx_clr),
        .load_val_i ('0),
        .up_i       (idx_up),
        .down_i     (1'b0),
        .cnt_o      (corr_idx)
    );

    assign isEn2     = is_en2_q;
    assign proto_err = proto_err_q;
    assign frame_cnt = frame_cnt_q;
    assign out_valid = corr_en;
    assign corr_last = corr_en && (corr_idx == LastIdx);

endmodule
